// File: rtl/slave_serial_port.sv
// slave_serial_port: serial bus slave executing single/burst reads and writes on a local word memory
module slave_serial_port #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic master_valid,
    input  logic master_ready,
    input  logic read_en,
    input  logic write_en,
    input  logic tx_address,
    input  logic tx_burst,
    input  logic tx_data,
    output logic slave_ready,
    output logic slave_valid,
    output logic rx_data,
    output logic tx_done
);
    localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RLOAD, RDATA, DONE} state_t;

    state_t                 state, state_nx;
    logic                   is_write;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BURST_WIDTH-1:0] burst;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [DATA_WIDTH-1:0]  rdata;
    logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];
    logic                   start;
    logic                   last_addr;
    logic                   last_data;
    logic                   more;

    assign start     = master_valid && (read_en ^ write_en);
    assign last_addr = cnt == CW'(ADDR_WIDTH - 1);
    assign last_data = cnt == CW'(DATA_WIDTH - 1);
    assign more      = burst != '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ADDR : IDLE;
            ADDR:    state_nx = master_valid && last_addr ? (is_write ? WDATA : RLOAD) : ADDR;
            WDATA:   state_nx = master_valid && last_data ? WRITE : WDATA;
            WRITE:   state_nx = more ? WDATA : DONE;
            RLOAD:   state_nx = RDATA;
            RDATA:   state_nx = master_ready && last_data ? (more ? RLOAD : DONE) : RDATA;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign slave_ready = state == IDLE;
    assign slave_valid = state == RDATA;
    assign rx_data     = (state == RDATA) && rdata[0];
    assign tx_done     = state == DONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr     <= '0;
            burst    <= '0;
            cnt      <= '0;
            wdata    <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) is_write <= write_en;
                ADDR: if (master_valid) begin
                    addr <= {tx_address, addr[ADDR_WIDTH-1:1]};
                    if (cnt < CW'(BURST_WIDTH)) burst <= {tx_burst, burst[BURST_WIDTH-1:1]};
                    cnt <= last_addr ? '0 : cnt + CW'(1);
                end
                WDATA: if (master_valid) begin
                    wdata <= {tx_data, wdata[DATA_WIDTH-1:1]};
                    cnt   <= last_data ? '0 : cnt + CW'(1);
                end
                WRITE: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    if (more) burst <= burst - BURST_WIDTH'(1);
                end
                RLOAD: rdata <= mem[addr];
                RDATA: if (master_ready) begin
                    rdata <= rdata >> 1;
                    cnt   <= last_data ? '0 : cnt + CW'(1);
                    if (last_data) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        if (more) burst <= burst - BURST_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == WRITE) mem[addr] <= wdata;
    end
endmodule
